// File: rtl/watchdog_timer_pkg.sv
// Shared CSR map, CTRL/STATUS bit positions and KICK magic for the watchdog.
// Used by watchdog_timer, which also honours the WATCHDOG_PRETIMEOUT_EN build macro.
package watchdog_timer_pkg;

  localparam logic [4:0] ADDR_CTRL       = 5'h0;
  localparam logic [4:0] ADDR_TIMEOUT    = 5'h1;
  localparam logic [4:0] ADDR_KICK       = 5'h2;
  localparam logic [4:0] ADDR_COUNT      = 5'h3;
  localparam logic [4:0] ADDR_STATUS     = 5'h4;
  localparam logic [4:0] ADDR_PRETIMEOUT = 5'h5;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_LOCK   = 1;
  localparam int CTRL_OE     = 2;
  localparam int CTRL_FRM    = 3;
  localparam int CTRL_IRQ_EN = 6;

  localparam int STATUS_TIMEOUT = 0;
  localparam int STATUS_PRETO   = 1;

  // Implemented CTRL bits; everything else reads as zero.
  localparam logic [7:0] CTRL_WMASK = 8'h4F;
  localparam logic [7:0] KICK_MAGIC = 8'h6B;

endpackage

// File: rtl/watchdog_timer.sv
// Board-management watchdog: CSR-programmed 8-bit down-counter driving reset/recovery/irq.
// Build macro WATCHDOG_PRETIMEOUT_EN adds the PRETIMEOUT register and STATUS.PRETO flag.
module watchdog_timer
  import watchdog_timer_pkg::*;
#(
  parameter logic [7:0] DEFAULT_TIMEOUT = 8'h3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  output logic [7:0] csr_do,
  output logic       wdt_out,
  output logic       force_recovery_mode,
  output logic       irq
);

  logic [7:0] r_ctrl;
  logic [7:0] r_timeout;
  logic [7:0] r_count;
  logic       r_flag_to;
  logic       r_wdt_out;
  logic       r_frm_out;
  logic       r_irq;

  logic [7:0] w_ctrl_next;
  logic [7:0] w_count_next;
  logic       w_set_to;
  logic       w_set_pre;
  logic       w_preto;
  logic       w_tick;
  logic       w_reload;

  logic w_wr_ctrl, w_wr_timeout, w_wr_status;
  assign w_wr_ctrl    = csr_we && (csr_a == ADDR_CTRL);
  assign w_wr_timeout = csr_we && (csr_a == ADDR_TIMEOUT);
  assign w_wr_status  = csr_we && (csr_a == ADDR_STATUS);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_ctrl_next = r_ctrl;
    if (w_wr_ctrl) begin
      w_ctrl_next = csr_di & CTRL_WMASK;
      if (r_ctrl[CTRL_LOCK]) begin
        w_ctrl_next[CTRL_EN]   = 1'b1;
        w_ctrl_next[CTRL_LOCK] = 1'b1;
      end
    end
  end

  // Counting uses the post-write EN so clearing EN on a tick cycle freezes the counter.
  assign w_reload = (csr_we && (csr_a == ADDR_KICK) && (csr_di == KICK_MAGIC))
                  || (!r_ctrl[CTRL_EN] && w_ctrl_next[CTRL_EN]);
  assign w_tick   = ce && r_ctrl[CTRL_EN] && w_ctrl_next[CTRL_EN];

  always_comb begin
    w_count_next = r_count;
    w_set_to     = 1'b0;
    if (w_reload) begin
      w_count_next = r_timeout;
    end else if (w_tick) begin
      if (r_count != 8'd0) begin
        w_count_next = r_count - 8'd1;
        w_set_to     = (r_count == 8'd1);
      end else begin
        w_set_to = (r_timeout == 8'd0);
      end
    end
  end

`ifdef WATCHDOG_PRETIMEOUT_EN
  logic [7:0] r_pretimeout;
  logic       r_preto;

  assign w_set_pre = !w_reload && w_tick && (r_count != 8'd0)
                   && (r_pretimeout != 8'd0) && ((r_count - 8'd1) == r_pretimeout);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pretimeout <= 8'h00;
      r_preto      <= 1'b0;
    end else begin
      if (csr_we && (csr_a == ADDR_PRETIMEOUT)) r_pretimeout <= csr_di;
      r_preto <= w_set_pre || (r_preto && !(w_wr_status && csr_di[STATUS_PRETO]));
    end
  end

  assign w_preto = r_preto;
`else
  assign w_set_pre = 1'b0;
  assign w_preto   = w_set_pre;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl    <= 8'h00;
      r_timeout <= DEFAULT_TIMEOUT;
      r_count   <= DEFAULT_TIMEOUT;
      r_flag_to <= 1'b0;
      r_wdt_out <= 1'b0;
      r_frm_out <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_ctrl    <= w_ctrl_next;
      r_count   <= w_count_next;
      if (w_wr_timeout) r_timeout <= csr_di;
      // A fresh expiry beats a simultaneous write-1-to-clear.
      r_flag_to <= w_set_to || (r_flag_to && !(w_wr_status && csr_di[STATUS_TIMEOUT]));
      r_wdt_out <= r_flag_to && r_ctrl[CTRL_OE];
      r_frm_out <= r_flag_to && r_ctrl[CTRL_FRM];
      r_irq     <= (r_flag_to || w_preto) && r_ctrl[CTRL_IRQ_EN];
    end
  end

  always_comb begin
    csr_do = 8'h00;
    case (csr_a)
      ADDR_CTRL:       csr_do = r_ctrl;
      ADDR_TIMEOUT:    csr_do = r_timeout;
      ADDR_COUNT:      csr_do = r_count;
      ADDR_STATUS:     csr_do = {6'b0, w_preto, r_flag_to};
`ifdef WATCHDOG_PRETIMEOUT_EN
      ADDR_PRETIMEOUT: csr_do = r_pretimeout;
`endif
      default:         csr_do = 8'h00;
    endcase
  end

  assign wdt_out             = r_wdt_out;
  assign force_recovery_mode = r_frm_out;
  assign irq                 = r_irq;

endmodule

// File: tb/tb_watchdog_timer.sv
// Self-checking bench for watchdog_timer: directed scenarios plus randomized CSR/ce traffic
// compared against a behavioural model; honours WATCHDOG_PRETIMEOUT_EN.
module tb_watchdog_timer;

`ifdef WATCHDOG_PRETIMEOUT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;
  logic       wdt_out, force_recovery_mode, irq;

  always #5 clk = ~clk;

  watchdog_timer #(.DEFAULT_TIMEOUT(8'h3)) dut (
    .clk(clk), .rst(rst), .ce(ce), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_do(csr_do), .wdt_out(wdt_out), .force_recovery_mode(force_recovery_mode), .irq(irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: register contents as plain bytes, updated once per clock edge.
  bit [7:0] m_ctrl, m_to, m_cnt, m_st, m_pre;
  bit       m_wdt, m_frm, m_irq;

  task automatic model_reset();
    m_ctrl = 8'h00; m_to = 8'h03; m_cnt = 8'h03; m_st = 8'h00; m_pre = 8'h00;
    m_wdt = 1'b0; m_frm = 1'b0; m_irq = 1'b0;
  endtask

  function automatic bit [7:0] model_read(input bit [4:0] a);
    case (a)
      5'h0: return m_ctrl;
      5'h1: return m_to;
      5'h3: return m_cnt;
      5'h4: return m_st;
      5'h5: return PRE ? m_pre : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_edge(input bit c, input bit [4:0] a, input bit [7:0] di, input bit w);
    bit [7:0] nctrl;
    bit       set_to, set_pre, running;
    nctrl = m_ctrl; set_to = 1'b0; set_pre = 1'b0;
    if (w && a == 5'h0) begin
      nctrl = di & 8'h4F;
      if (m_ctrl[1]) nctrl = nctrl | 8'h03;
    end
    m_wdt = m_st[0] & m_ctrl[2];
    m_frm = m_st[0] & m_ctrl[3];
    m_irq = (m_st[0] | m_st[1]) & m_ctrl[6];
    running = m_ctrl[0] && nctrl[0];
    if ((w && a == 5'h2 && di == 8'h6B) || (!m_ctrl[0] && nctrl[0])) begin
      m_cnt = m_to;
    end else if (c && running) begin
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) set_to = 1'b1;
        if (PRE && m_pre != 0 && m_cnt == m_pre) set_pre = 1'b1;
      end else if (m_to == 0) begin
        set_to = 1'b1;
      end
    end
    if (w && a == 5'h4) m_st = m_st & ~(di & 8'h03);
    if (set_to)  m_st[0] = 1'b1;
    if (set_pre) m_st[1] = 1'b1;
    if (w && a == 5'h1) m_to = di;
    if (PRE && w && a == 5'h5) m_pre = di;
    m_ctrl = nctrl;
  endtask

  // One clock: drive at negedge, check read data before the edge, check outputs after it.
  task automatic cycle(input bit c, input bit [4:0] a, input bit [7:0] di, input bit w);
    ce = c; csr_a = a; csr_di = di; csr_we = w;
    #1 check("csr_do", csr_do, model_read(a));
    @(posedge clk);
    model_edge(c, a, di, w);
    @(negedge clk);
    check("wdt_out", {7'b0, wdt_out}, {7'b0, m_wdt});
    check("force_recovery_mode", {7'b0, force_recovery_mode}, {7'b0, m_frm});
    check("irq", {7'b0, irq}, {7'b0, m_irq});
    ce = 1'b0; csr_we = 1'b0;
  endtask

  task automatic peek(input string tag, input bit [4:0] a, input bit [7:0] exp);
    ce = 1'b0; csr_we = 1'b0; csr_a = a;
    #1 check(tag, csr_do, exp);
    cycle(1'b0, a, 8'h00, 1'b0);
  endtask

  task automatic expect_out(input string tag, input bit w, input bit f, input bit i);
    check(tag, {5'b0, wdt_out, force_recovery_mode, irq}, {5'b0, w, f, i});
  endtask

  // Asserts reset between edges and checks it takes effect without a clock.
  task automatic do_reset();
    #2 rst = 1'b0; csr_a = 5'h3; csr_we = 1'b0; ce = 1'b0;
    model_reset();
    #1;
    check("async_rst_out", {5'b0, wdt_out, force_recovery_mode, irq}, 8'h00);
    check("async_rst_cnt", csr_do, 8'h03);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bit [7:0] di;
    bit [4:0] a;
    bit       c, w;
    rst = 1'b0; ce = 1'b0; csr_a = 5'h0; csr_di = 8'h00; csr_we = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    peek("rst_ctrl", 5'h0, 8'h00);
    peek("rst_timeout", 5'h1, 8'h03);
    peek("rst_count", 5'h3, 8'h03);
    expect_out("rst_outputs", 1'b0, 1'b0, 1'b0);

    // Basic expiry with IRQ_EN only.
    cycle(1'b0, 5'h0, 8'h41, 1'b1);
    peek("a_cnt3", 5'h3, 8'h03);
    for (int k = 2; k >= 0; k--) begin
      cycle(1'b1, 5'h3, 8'h00, 1'b0);
      peek("a_cnt_tick", 5'h3, 8'(k));
    end
    peek("a_status", 5'h4, 8'h01);
    expect_out("a_outputs", 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 5'h4, 8'h01, 1'b1);
    cycle(1'b0, 5'h4, 8'h00, 1'b0);
    expect_out("a_irq_cleared", 1'b0, 1'b0, 1'b0);
    peek("a_status_clr", 5'h4, 8'h00);
    cycle(1'b0, 5'h2, 8'h00, 1'b1);
    peek("a_bad_kick", 5'h3, 8'h00);

    // Periodic kicking keeps the timer alive; stopping lets it expire.
    cycle(1'b0, 5'h0, 8'h00, 1'b1);
    cycle(1'b0, 5'h1, 8'h05, 1'b1);
    cycle(1'b0, 5'h0, 8'h0D, 1'b1);
    for (int k = 0; k < 5; k++) begin
      repeat (4) cycle(1'b1, 5'h3, 8'h00, 1'b0);
      cycle(1'b0, 5'h2, 8'h6B, 1'b1);
    end
    expect_out("b_kicked_out", 1'b0, 1'b0, 1'b0);
    peek("b_kicked_cnt", 5'h3, 8'h05);
    repeat (4) cycle(1'b1, 5'h3, 8'h00, 1'b0);
    expect_out("b_before_exp", 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 5'h3, 8'h00, 1'b0);
    peek("b_cnt0", 5'h3, 8'h00);
    expect_out("b_expired", 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 5'h2, 8'h6B, 1'b1);
    peek("kick_with_ce", 5'h3, 8'h05);
    cycle(1'b0, 5'h4, 8'h01, 1'b1);

    // LOCK holds EN and LOCK; counting continues.
    cycle(1'b0, 5'h0, 8'h03, 1'b1);
    cycle(1'b0, 5'h0, 8'h00, 1'b1);
    peek("c_lock", 5'h0, 8'h03);
    cycle(1'b1, 5'h3, 8'h00, 1'b0);
    peek("c_count", 5'h3, 8'h04);
    repeat (3) cycle(1'b1, 5'h3, 8'h00, 1'b0);
    cycle(1'b1, 5'h4, 8'h01, 1'b1);
    peek("w1c_vs_expiry", 5'h4, 8'h01);

    do_reset();
`ifdef WATCHDOG_PRETIMEOUT_EN
    cycle(1'b0, 5'h1, 8'h08, 1'b1);
    cycle(1'b0, 5'h5, 8'h02, 1'b1);
    cycle(1'b0, 5'h0, 8'h41, 1'b1);
    repeat (6) cycle(1'b1, 5'h3, 8'h00, 1'b0);
    peek("d_status", 5'h4, 8'h02);
    expect_out("d_irq", 1'b0, 1'b0, 1'b1);
`else
    cycle(1'b0, 5'h5, 8'hFF, 1'b1);
    peek("no_pretimeout", 5'h5, 8'h00);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        c = ($urandom_range(0, 2) == 0);
        w = ($urandom_range(0, 3) == 0);
        a = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
        di = 8'($urandom);
        case (a)
          5'h0: if ($urandom_range(0, 19) != 0) di[1] = 1'b0;
          5'h1: di = 8'($urandom_range(0, 6));
          5'h2: if ($urandom_range(0, 1) == 0) di = 8'h6B;
          5'h5: di = 8'($urandom_range(0, 4));
          default: ;
        endcase
        cycle(c, a, di, w);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
